// File: rtl/apb_master_arbiter.sv
// Two-requester APB master with round-robin arbitration, wait states and timeout.
// Ports: clk, rst (async high); req/we/addr/wdata/done per requester;
//        rd_data, err, busy; APB master signals paddr/pwrite/psel/penable/pwdata,
//        APB inputs prdata/pready.
module apb_master_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic [DATA_W-1:0] rd_data,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [7:0]        count_q, count_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            count_q   <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            count_q   <= count_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign timeout_hit = !pready && (count_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        count_d   = count_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        rd_data_d = rd_data_q;
        done0     = 1'b0;
        done1     = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that did not own the bus last wins.
                    grant_d  = (req0 && req1) ? ~last_q : req1;
                    last_d   = grant_d;
                    paddr_d  = grant_d ? addr1 : addr0;
                    pwrite_d = grant_d ? we1 : we0;
                    pwdata_d = grant_d ? wdata1 : wdata0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                count_d = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready || timeout_hit) begin
                    done0 = !grant_q;
                    done1 = grant_q;
                    err   = !pready;
                    // An aborted read returns zero rather than stale bus data.
                    if (!pwrite_q) begin
                        rd_data_d = pready ? prdata : '0;
                    end
                    state_d = IDLE;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus strobes decode the state register directly so reset drops them at once.
    assign psel    = (state_q != IDLE);
    assign penable = (state_q == ACCESS);
    assign busy    = psel;
    assign paddr   = paddr_q;
    assign pwrite  = pwrite_q;
    assign pwdata  = pwdata_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: transaction-level model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_apb_master_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          done0, done1;
    logic [DW-1:0] rd_data;
    logic          err, busy;
    logic [AW-1:0] paddr;
    logic          pwrite, psel, penable;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;

    int n_pass = 0;
    int n_total = 0;

    apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .done0(done0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .done1(done1),
        .rd_data(rd_data), .err(err), .busy(busy),
        .paddr(paddr), .pwrite(pwrite), .psel(psel),
        .penable(penable), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 clk = ~clk;

    // Transaction model: a transfer is active from grant until it finishes;
    // m_k counts bus cycles since grant (1 = SETUP, 2.. = ACCESS cycles).
    bit            m_active;
    bit            m_owner;
    bit            m_last;
    int            m_k;
    logic [AW-1:0] m_paddr;
    logic          m_pwrite;
    logic [DW-1:0] m_pwdata;
    logic [DW-1:0] m_rd;

    function automatic bit m_in_access();
        return m_active && (m_k >= 2);
    endfunction

    function automatic bit m_expired();
        return (m_k - 1) == TO;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0;
            m_owner  = 0;
            m_last   = 1;
            m_k      = 0;
            m_paddr  = '0;
            m_pwrite = 0;
            m_pwdata = '0;
            m_rd     = '0;
        end else if (!m_active) begin
            if (req0 || req1) begin
                if (req0 && req1) m_owner = !m_last;
                else              m_owner = req1;
                m_last   = m_owner;
                m_paddr  = m_owner ? addr1 : addr0;
                m_pwrite = m_owner ? we1 : we0;
                m_pwdata = m_owner ? wdata1 : wdata0;
                m_active = 1;
                m_k      = 1;
            end
        end else if (m_in_access() && (pready || m_expired())) begin
            if (!m_pwrite) m_rd = pready ? prdata : '0;
            m_active = 0;
        end else begin
            m_k = m_k + 1;
        end
    end

    logic [78:0] cyc_exp, cyc_act;
    bit          e_fin, e_err;

    always @(negedge clk) begin
        e_fin = m_in_access() && (pready || m_expired());
        e_err = m_in_access() && !pready && m_expired();
        cyc_exp = {m_active, m_in_access(), m_active, m_pwrite,
                   e_fin && !m_owner, e_fin && m_owner, e_err,
                   m_paddr, m_pwdata, m_rd};
        cyc_act = {psel, penable, busy, pwrite, done0, done1, err,
                   paddr, pwdata, rd_data};
        n_total++;
        if (cyc_act === cyc_exp) n_pass++;
        else $display("FAIL cycle@%0t: got %h want %h",
                      $time, cyc_act, cyc_exp);
    end

    task automatic hchk(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic timeout_fail(input string nm);
        n_total++;
        $display("FAIL %s: got no event want event", nm);
    endtask

    task automatic wait_pen();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (penable) return;
        end
        timeout_fail("wait_penable");
    endtask

    task automatic wait_done(input bit who);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (who ? done1 : done0) return;
        end
        timeout_fail("wait_done");
    endtask

    task automatic edge_in();
        @(posedge clk);
        #1;
    endtask

    int   n_acc;
    bit   err_seen;
    int   k_done;
    int   cyc;
    int   gap_low;
    bit   order [4];
    int   t_done [4];

    initial begin
        rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        prdata = '0; pready = 0;
        repeat (2) @(negedge clk);
        hchk("reset_psel", {31'd0, psel}, 32'd0);
        hchk("reset_pen", {31'd0, penable}, 32'd0);
        hchk("reset_rd", rd_data, 32'd0);
        rst = 0;

        // Single zero-wait write
        edge_in();
        req0 = 1; we0 = 1; addr0 = 8'h04; wdata0 = 32'hDEADBEEF; pready = 1;
        @(negedge clk);
        hchk("t1_idle_psel", {31'd0, psel}, 32'd0);
        @(negedge clk);
        hchk("t1_setup", {28'd0, psel, penable, 2'b00}, {28'd0, 4'b1000});
        hchk("t1_paddr", {24'd0, paddr}, 32'h04);
        hchk("t1_pwdata", pwdata, 32'hDEADBEEF);
        @(negedge clk);
        hchk("t1_access", {29'd0, penable, done0, err}, 32'b110);
        edge_in();
        req0 = 0;
        @(negedge clk);
        hchk("t1_after", {31'd0, psel}, 32'd0);

        // Read with 3 wait states
        edge_in();
        req1 = 1; we1 = 0; addr1 = 8'h10; pready = 0; prdata = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        hchk("t2_setup_psel", {31'd0, psel}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            hchk("t2_wait", {30'd0, penable, done1}, 32'b10);
        end
        edge_in();
        pready = 1; prdata = 32'h12345678;
        @(negedge clk);
        hchk("t2_done1", {31'd0, done1}, 32'd1);
        edge_in();
        req1 = 0;
        @(negedge clk);
        hchk("t2_rd_data", rd_data, 32'h12345678);

        // Timeout on a read
        edge_in();
        req0 = 1; we0 = 0; addr0 = 8'h30; pready = 0; prdata = 32'hAAAA5555;
        n_acc = 0; err_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (penable) n_acc++;
            if (done0) begin
                err_seen = err;
                break;
            end
        end
        hchk("t4_acc_cycles", n_acc, TO);
        hchk("t4_err", {31'd0, err_seen}, 32'd1);
        edge_in();
        req0 = 0;
        @(negedge clk);
        hchk("t4_rd_zero", rd_data, 32'd0);
        hchk("t4_idle", {31'd0, psel}, 32'd0);

        // Simultaneous requests from reset
        @(negedge clk) rst = 1;
        @(negedge clk) rst = 0;
        edge_in();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        addr0 = 8'h20; addr1 = 8'h24;
        wdata0 = 32'h0000_00A0; wdata1 = 32'h0000_00A1; pready = 1;
        k_done = 0; cyc = 0; gap_low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (k_done >= 1 && !psel) gap_low++;
            if (done0 || done1) begin
                order[k_done] = done1;
                t_done[k_done] = cyc;
                k_done++;
                if (k_done == 4) break;
            end
        end
        edge_in();
        req0 = 0; req1 = 0;
        hchk("t3_ndone", k_done, 4);
        for (int i = 0; i < 4; i++)
            hchk("t3_order", {31'd0, order[i]}, i % 2);
        for (int i = 1; i < 4; i++)
            hchk("t3_spacing", t_done[i] - t_done[i-1], 3);
        hchk("t3_gap_low", gap_low, 3);

        // Reset in the middle of ACCESS
        edge_in();
        req0 = 1; we0 = 1; addr0 = 8'h40; wdata0 = 32'h11112222; pready = 0;
        wait_pen();
        #2 rst = 1;
        req0 = 0;
        #1;
        hchk("t5_rst_strobes", {29'd0, psel, penable, done0}, 32'd0);
        @(negedge clk) rst = 0;
        edge_in();
        req0 = 1; addr0 = 8'h44; wdata0 = 32'h55556666; pready = 1;
        wait_done(0);
        hchk("t5_paddr", {24'd0, paddr}, 32'h44);
        hchk("t5_err", {31'd0, err}, 32'd0);
        edge_in();
        req0 = 0;

        // Address change during ACCESS is ignored
        edge_in();
        req0 = 1; we0 = 1; addr0 = 8'h08; wdata0 = 32'h0BADC0DE; pready = 0;
        wait_pen();
        edge_in();
        addr0 = 8'hFF;
        @(negedge clk);
        hchk("t6_paddr_hold", {24'd0, paddr}, 32'h08);
        edge_in();
        pready = 1;
        @(negedge clk);
        hchk("t6_done", {23'd0, done0, paddr}, {23'd0, 1'b1, 8'h08});
        edge_in();
        req0 = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-requester APB master: arbitrates between two internal requesters and sequences the shared APB bus through SETUP and ACCESS phases.
- Supports wait states via pready and aborts stalled transfers with a timeout.
- Sits between test or control engines and the APB register slave, replacing direct task-driven bus stimulus with synthesizable sequencing.

Parameters:
- ADDR_W, 8, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, max ACCESS cycles waiting for pready before abort (legal range 1..255)

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  asynchronous active-high reset
- req0  input  1  requester 0 transfer request (level)
- we0  input  1  requester 0 direction (1=write)
- addr0  input  ADDR_W  requester 0 address
- wdata0  input  DATA_W  requester 0 write data
- done0  output  1  requester 0 completion strobe
- req1, we1, addr1, wdata1, done1  same as requester 0, for requester 1
- rd_data  output  DATA_W  last read data
- err  output  1  timeout strobe, coincident with done
- busy  output  1  high in SETUP or ACCESS
- paddr  output  ADDR_W  APB address
- pwrite  output  1  APB direction
- psel  output  1  APB select
- penable  output  1  APB enable
- pwdata  output  DATA_W  APB write data
- prdata  input  DATA_W  APB read data
- pready  input  1  APB ready; tie high for zero-wait slaves

Behaviour:
- Reset: async on rst high. State=IDLE. psel, penable, pwrite, paddr, pwdata, rd_data, err, busy, done0 and done1 all 0. Round-robin pointer last=1, so requester 0 wins the first tie.
- Requester handshake:
  - reqN, weN, addrN and wdataN are held stable from assertion until the cycle doneN=1.
  - reqN is deasserted in the cycle after doneN unless a new transfer is wanted.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - psel=0, penable=0.
  - If any req is high: grant one requester and load paddr, pwrite and pwdata from it (registered).
  - Set last=grant, go to SETUP.
  - Arbitration:
    - Both requesting: grant = !last.
    - Single request: grant to that requester.
- SETUP: psel=1, penable=0, busy=1. Always go to ACCESS next cycle; timeout counter cleared.
- ACCESS: psel=1, penable=1, busy=1. paddr, pwrite and pwdata are held unchanged.
  - pready=1: done[grant]=1 in this same cycle (combinational from state, pready, grant). If read, rd_data<=prdata at this edge. Go to IDLE.
  - pready=0 and count==TIMEOUT-1: done[grant]=1 and err=1 this cycle. If read, rd_data<=0. Go to IDLE.
  - Otherwise: count+1, stay in ACCESS.
- Latency:
  - Request seen in IDLE cycle t: SETUP at t+1, ACCESS at t+2.
  - Zero-wait done at t+2. Next transfer earliest SETUP at t+4 (one IDLE cycle between transfers, psel low).
- rd_data valid from the cycle after a read's done; held until the next read completes. Writes leave rd_data unchanged.
- done0 and done1 are never high together. err is only high together with a done.
- Request changes during SETUP/ACCESS are ignored.
- A newly arriving req from the non-owner waits. It wins at the next IDLE because last points at the owner.
- Reset mid-transfer: psel and penable drop immediately, no done or err is issued, the transfer is lost, last returns to 1.
- A pready high during IDLE or SETUP has no effect.

Test Plan:
- Single write, zero wait: req0, we0=1, addr0=0x04, wdata0=0xDEADBEEF, pready=1.
  - -> SETUP cycle: psel=1, penable=0, paddr=0x04, pwdata=0xDEADBEEF.
  - -> Next cycle: penable=1, done0=1, err=0.
  - -> Following cycle: psel=0.
- Read with 3 wait states: req1, we1=0, addr1=0x10; pready low 3 ACCESS cycles, then high with prdata=0x12345678.
  - -> done1 in the 4th ACCESS cycle.
  - -> rd_data=0x12345678 from the next cycle.
- Simultaneous requests from reset: req0 and req1 high together and held after each done.
  - -> Grant order 0, 1, 0, 1.
  - -> psel low exactly one cycle between transfers.
- Timeout: TIMEOUT=16, read request, pready held 0.
  - -> In the 16th ACCESS cycle: done and err=1, rd_data=0.
  - -> Returns to IDLE.
- Reset mid-ACCESS: assert rst while penable=1.
  - -> psel and penable 0 without waiting for a clock edge; no done.
  - -> After release, a new req0 transfer completes normally.
- Request stability: change addr0 during ACCESS.
  - -> paddr unchanged until done0.
